unified_sram_arbiter: RTL and testbench
=======================================

# unified_sram_arbiter

Shares a single synchronous SRAM port between the CPU's instruction-fetch requester and its data load/store requester. It sits between the CPU core and a unified instruction/data SRAM with a fixed 1-cycle read latency. It arbitrates round-robin, sequences each access as a grant/response pair, and returns an ack and read data to the winning requester. It also keeps a saturating count of cycles lost to port contention, for use as a performance counter.

## Interface
- ADDR_W, 32, address width of requesters and SRAM
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction fetch request, held until inst_ack
- inst_addr  in  ADDR_W  fetch address, stable while inst_req=1
- inst_ack  out  1  one-cycle pulse: fetch complete, inst_rdata valid
- inst_rdata  out  DATA_W  fetched word; valid only while inst_ack=1, else 0
- data_req  in  1  data access request, held until data_ack
- data_wen  in  DATA_W/8  byte enables; 0 = read, nonzero = write
- data_addr  in  ADDR_W  data address, stable while data_req=1
- data_wdata  in  DATA_W  store data, stable while data_req=1
- data_ack  out  1  one-cycle pulse: access complete
- data_rdata  out  DATA_W  load data while data_ack=1 for a read; 0 otherwise, including write acks
- sram_en  out  1  SRAM access enable (grant cycle)
- sram_wen  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en
- conflict_cnt  out  32  saturating contention-cycle counter

## Operation
- States:
  - IDLE: no access issued last cycle.
  - BUSY_I: fetch issued last cycle.
  - BUSY_D: data access issued last cycle.
- Grant cycle:
  - sram_en=1.
  - sram_addr, sram_wen and sram_wdata are driven combinationally from the granted requester.
  - An instruction grant drives sram_wen=0 and sram_wdata=0.
  - With no grant, all sram_* outputs are 0.
- IDLE:
  - Only inst_req: grant I, next state BUSY_I.
  - Only data_req: grant D, next state BUSY_D.
  - Both: grant the requester selected by the round-robin pointer `last`. `last`=D grants I; `last`=I grants D.
  - Neither: stay IDLE.
  - `last` updates on every grant to the granted requester.
- BUSY_I (symmetric for BUSY_D):
  - inst_ack=1 and inst_rdata=sram_rdata.
  - The acked requester's req is stale in this cycle and is ignored.
  - If data_req=1, grant D in this same cycle and go to BUSY_D. Otherwise go to IDLE.
  - The same requester is never granted in its own ack cycle. Its earliest re-grant is the cycle after its ack.
- Data write:
  - The access is acked one cycle after grant.
  - data_rdata=0 in the ack cycle. A registered "was-write" flag is captured at grant time.
- conflict_cnt:
  - Increments by 1 in each cycle where sram_en=1 and the non-granted requester has req=1 and is not being acked that cycle.
  - Saturates at 32'hFFFF_FFFF.
- Reset:
  - Forces IDLE, `last`=D (instruction wins the first tie), was-write=0, conflict_cnt=0.
  - Combinationally forces sram_en=0, sram_wen=0 and both acks 0 while reset=1.
  - An access in flight at reset is dropped with no ack. The requester re-issues after reset.

## Timing
- Latency:
  - Uncontended request seen in IDLE at cycle N: grant at N, ack at N+1.
  - Loser of a tie: granted at N+1 during the winner's ack cycle, acked at N+2.
- Throughput:
  - One access per cycle while both requesters alternate.
  - A single requester alone gets one access per 2 cycles.
- Outputs during reset and the first cycle after: all 0.
- inst_rdata and data_rdata are combinational from sram_rdata, gated by the registered state. No extra register stage.
- A request deasserted before its ack is a protocol violation; behaviour is undefined.

## Test plan
- Lone fetch:
  - Stimulus: inst_req=1, inst_addr=0xBFC00000 at cycle 1; SRAM returns 0x24080001.
  - Required: sram_en=1 with sram_addr=0xBFC00000 at cycle 1; inst_ack=1 and inst_rdata=0x24080001 at cycle 2; conflict_cnt=0.
- Simultaneous requests after reset:
  - Stimulus: inst_req=1 and data_req=1 (read of 0x80000010) at cycle 1.
  - Required: I granted at cycle 1; D granted at cycle 2 alongside inst_ack; data_ack at cycle 3; conflict_cnt=1.
- Alternation:
  - Stimulus: both requesters continuously re-request for 10 cycles.
  - Required: grants alternate I,D,I,D; an ack occurs every cycle from cycle 2; neither requester is granted twice in a row.
- Data write:
  - Stimulus: data_wen=4'b0011, data_addr=0x80000004, data_wdata=0x0000BEEF.
  - Required: sram_wen=4'b0011 and sram_wdata=0x0000BEEF in the grant cycle; data_ack next cycle with data_rdata=0.
- Reset mid-access:
  - Stimulus: reset asserted in the cycle after a data grant.
  - Required: no data_ack; all outputs 0; after reset a tied request grants I first.
- Counter saturation:
  - Stimulus: force conflict_cnt to 0xFFFFFFFE via the bench, then apply 3 contention cycles.
  - Required: conflict_cnt holds 0xFFFFFFFF.

Source files
------------

// File: rtl/unified_sram_arbiter.sv
// ============================================================================
// unified_sram_arbiter
// ----------------------------------------------------------------------------
// Shares one synchronous SRAM port (1-cycle read latency) between the CPU's
// instruction-fetch requester and its data load/store requester.
//
// Arbitration is round-robin on ties. Each access is a grant/response pair:
//   - grant cycle: sram_* driven from the winner
//   - next cycle:  ack to the winner with read data taken from the SRAM
// While one requester is being acked, the other may be granted in the same
// cycle, so two alternating requesters reach one access per cycle.
//
// A saturating counter records cycles in which a requester was left waiting
// for the port.
//
// Ports
//   i_clk, i_reset                   clock, synchronous active-high reset
//   i_inst_req/i_inst_addr           fetch request (held until ack)
//   o_inst_ack/o_inst_rdata          fetch completion pulse + data
//   i_data_req/i_data_wen/
//   i_data_addr/i_data_wdata         data request (wen==0 -> read)
//   o_data_ack/o_data_rdata          data completion pulse + load data
//   o_sram_en/o_sram_wen/
//   o_sram_addr/o_sram_wdata         SRAM command (grant cycle only)
//   i_sram_rdata                     SRAM read data, valid cycle after en
//   o_conflict_cnt                   saturating contention-cycle count
// ============================================================================
module unified_sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_inst_req,
    input  logic [ADDR_W-1:0]     i_inst_addr,
    output logic                  o_inst_ack,
    output logic [DATA_W-1:0]     o_inst_rdata,
    input  logic                  i_data_req,
    input  logic [DATA_W/8-1:0]   i_data_wen,
    input  logic [ADDR_W-1:0]     i_data_addr,
    input  logic [DATA_W-1:0]     i_data_wdata,
    output logic                  o_data_ack,
    output logic [DATA_W-1:0]     o_data_rdata,
    output logic                  o_sram_en,
    output logic [DATA_W/8-1:0]   o_sram_wen,
    output logic [ADDR_W-1:0]     o_sram_addr,
    output logic [DATA_W-1:0]     o_sram_wdata,
    input  logic [DATA_W-1:0]     i_sram_rdata,
    output logic [31:0]           o_conflict_cnt
);

    localparam int BE_W = DATA_W / 8;

    // State names the access issued in the previous cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last;        // 1'b1 = data was granted last, 1'b0 = fetch
    logic        r_was_write;   // access in flight on the D side is a write
    logic [31:0] r_conflict_cnt;

    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_inst_ack;
    logic        w_data_ack;
    logic        w_conflict;
    logic        w_cnt_sat;

    // Grant selection. The requester being acked in BUSY_x is not considered:
    // its req line still shows the completed access.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!i_reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_inst_req && i_data_req) begin
                        // last==D hands the tie to fetch, last==I to data
                        w_grant_i = r_last;
                        w_grant_d = ~r_last;
                    end else begin
                        w_grant_i = i_inst_req;
                        w_grant_d = i_data_req;
                    end
                end
                ST_BUSY_I: begin
                    w_grant_d = i_data_req;
                end
                ST_BUSY_D: begin
                    w_grant_i = i_inst_req;
                end
                default: begin
                    w_grant_i = 1'b0;
                    w_grant_d = 1'b0;
                end
            endcase
        end else begin
            w_grant_i = 1'b0;
            w_grant_d = 1'b0;
        end
    end

    // Acks follow the registered state; reset suppresses them immediately.
    assign w_inst_ack = !i_reset && (r_state == ST_BUSY_I);
    assign w_data_ack = !i_reset && (r_state == ST_BUSY_D);

    // A waiting requester that is not simultaneously completing counts as lost.
    assign w_conflict = (w_grant_i && i_data_req && !w_data_ack) ||
                        (w_grant_d && i_inst_req && !w_inst_ack);
    assign w_cnt_sat  = &r_conflict_cnt;

    assign o_sram_en    = w_grant_i | w_grant_d;
    assign o_sram_addr  = w_grant_i ? i_inst_addr :
                          (w_grant_d ? i_data_addr : {ADDR_W{1'b0}});
    assign o_sram_wen   = w_grant_d ? i_data_wen   : {BE_W{1'b0}};
    assign o_sram_wdata = w_grant_d ? i_data_wdata : {DATA_W{1'b0}};

    assign o_inst_ack   = w_inst_ack;
    assign o_data_ack   = w_data_ack;
    assign o_inst_rdata = w_inst_ack ? i_sram_rdata : {DATA_W{1'b0}};
    assign o_data_rdata = (w_data_ack && !r_was_write) ? i_sram_rdata
                                                       : {DATA_W{1'b0}};
    assign o_conflict_cnt = r_conflict_cnt;

    // Access sequencing, round-robin pointer, write flag and contention count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_last         <= 1'b1;
            r_was_write    <= 1'b0;
            r_conflict_cnt <= 32'd0;
        end else begin
            if (w_grant_i) begin
                r_state <= ST_BUSY_I;
                r_last  <= 1'b0;
            end else if (w_grant_d) begin
                r_state     <= ST_BUSY_D;
                r_last      <= 1'b1;
                r_was_write <= |i_data_wen;
            end else begin
                r_state <= ST_IDLE;
            end

            if (w_conflict && !w_cnt_sat) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end else begin
                r_conflict_cnt <= r_conflict_cnt;
            end
        end
    end

endmodule

// File: tb/tb_unified_sram_arbiter.sv
// ============================================================================
// tb_unified_sram_arbiter
// Directed, self-checking bench for unified_sram_arbiter. Inputs change 1ns
// after the rising edge, outputs are compared 2ns after it. The SRAM is
// modelled by driving i_sram_rdata with the word expected in each ack cycle.
// ============================================================================
module tb_unified_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] conflict_cnt;

    int n_total = 0;
    int n_pass  = 0;

    unified_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_inst_req     (inst_req),
        .i_inst_addr    (inst_addr),
        .o_inst_ack     (inst_ack),
        .o_inst_rdata   (inst_rdata),
        .i_data_req     (data_req),
        .i_data_wen     (data_wen),
        .i_data_addr    (data_addr),
        .i_data_wdata   (data_wdata),
        .o_data_ack     (data_ack),
        .o_data_rdata   (data_rdata),
        .o_sram_en      (sram_en),
        .o_sram_wen     (sram_wen),
        .o_sram_addr    (sram_addr),
        .o_sram_wdata   (sram_wdata),
        .i_sram_rdata   (sram_rdata),
        .o_conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    initial begin
        reset      = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = 32'd0;
        data_req   = 1'b0;
        data_wen   = 4'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        sram_rdata = 32'd0;

        // ---------------- reset behaviour ----------------
        tick();
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0040;
        settle();
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_addr", sram_addr, 32'd0);
        chk("rst_inst_ack", 32'(inst_ack), 32'd0);
        chk("rst_cnt", conflict_cnt, 32'd0);

        tick();
        reset      = 1'b0;
        inst_req   = 1'b0;
        sram_rdata = 32'hFFFF_FFFF;
        settle();
        chk("post_rst_en", 32'(sram_en), 32'd0);
        chk("post_rst_inst_ack", 32'(inst_ack), 32'd0);
        chk("post_rst_inst_rdata", inst_rdata, 32'd0);
        chk("post_rst_data_rdata", data_rdata, 32'd0);

        // ---------------- lone fetch ----------------
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        settle();
        chk("fetch_grant_en", 32'(sram_en), 32'd1);
        chk("fetch_grant_addr", sram_addr, 32'hBFC0_0000);
        chk("fetch_grant_wen", 32'(sram_wen), 32'd0);
        tick();
        inst_req   = 1'b0;
        sram_rdata = 32'h2408_0001;
        settle();
        chk("fetch_ack", 32'(inst_ack), 32'd1);
        chk("fetch_rdata", inst_rdata, 32'h2408_0001);
        chk("fetch_no_data_ack", 32'(data_ack), 32'd0);
        chk("fetch_ack_cycle_en", 32'(sram_en), 32'd0);
        chk("fetch_cnt", conflict_cnt, 32'd0);
        tick();
        settle();
        chk("fetch_ack_pulse", 32'(inst_ack), 32'd0);
        chk("fetch_rdata_gated", inst_rdata, 32'd0);

        // ---------------- data write ----------------
        data_req   = 1'b1;
        data_wen   = 4'b0011;
        data_addr  = 32'h8000_0004;
        data_wdata = 32'h0000_BEEF;
        settle();
        chk("wr_grant_en", 32'(sram_en), 32'd1);
        chk("wr_grant_addr", sram_addr, 32'h8000_0004);
        chk("wr_grant_wen", 32'(sram_wen), 32'h3);
        chk("wr_grant_wdata", sram_wdata, 32'h0000_BEEF);
        tick();
        data_req   = 1'b0;
        data_wen   = 4'd0;
        data_wdata = 32'd0;
        sram_rdata = 32'hDEAD_BEEF;
        settle();
        chk("wr_ack", 32'(data_ack), 32'd1);
        chk("wr_ack_rdata_zero", data_rdata, 32'd0);

        // ---------------- reset mid-access ----------------
        tick();
        data_req  = 1'b1;
        data_addr = 32'h8000_0008;
        settle();
        chk("rm_grant_en", 32'(sram_en), 32'd1);
        tick();
        reset      = 1'b1;
        data_req   = 1'b0;
        sram_rdata = 32'hCAFE_F00D;
        settle();
        chk("rm_no_data_ack", 32'(data_ack), 32'd0);
        chk("rm_data_rdata", data_rdata, 32'd0);
        chk("rm_sram_en", 32'(sram_en), 32'd0);
        tick();
        reset = 1'b0;
        settle();
        chk("rm_after_no_ack", 32'(data_ack), 32'd0);
        chk("rm_after_en", 32'(sram_en), 32'd0);

        // ---------------- simultaneous requests after reset ----------------
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_1000;
        data_req  = 1'b1;
        data_addr = 32'h8000_0010;
        settle();
        chk("tie_grant_i_addr", sram_addr, 32'h0000_1000);
        chk("tie_grant_en", 32'(sram_en), 32'd1);
        tick();
        inst_req   = 1'b0;
        sram_rdata = 32'h1111_2222;
        settle();
        chk("tie_inst_ack", 32'(inst_ack), 32'd1);
        chk("tie_inst_rdata", inst_rdata, 32'h1111_2222);
        chk("tie_grant_d_en", 32'(sram_en), 32'd1);
        chk("tie_grant_d_addr", sram_addr, 32'h8000_0010);
        chk("tie_cnt", conflict_cnt, 32'd1);
        tick();
        data_req   = 1'b0;
        sram_rdata = 32'h1122_3344;
        settle();
        chk("tie_data_ack", 32'(data_ack), 32'd1);
        chk("tie_data_rdata", data_rdata, 32'h1122_3344);
        chk("tie_no_inst_ack", 32'(inst_ack), 32'd0);
        chk("tie_cnt_hold", conflict_cnt, 32'd1);

        // ---------------- alternation ----------------
        tick();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0100;
        data_req  = 1'b1;
        data_addr = 32'h0000_0200;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk($sformatf("alt_en_%0d", k), 32'(sram_en), 32'd1);
            chk($sformatf("alt_addr_%0d", k), sram_addr,
                (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            if (k >= 1) begin
                chk($sformatf("alt_iack_%0d", k), 32'(inst_ack), (k % 2 == 1) ? 32'd1 : 32'd0);
                chk($sformatf("alt_dack_%0d", k), 32'(data_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            end
            tick();
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        settle();
        chk("alt_final_dack", 32'(data_ack), 32'd1);
        chk("alt_cnt", conflict_cnt, 32'd2);

        // ---------------- counter saturation ----------------
        tick();
        force dut.r_conflict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_conflict_cnt;
        settle();
        chk("sat_preload", conflict_cnt, 32'hFFFF_FFFE);
        for (int r = 0; r < 3; r++) begin
            inst_req = 1'b1;
            data_req = 1'b1;
            settle();
            chk($sformatf("sat_tie_en_%0d", r), 32'(sram_en), 32'd1);
            tick();
            inst_req = 1'b0;
            settle();
            chk($sformatf("sat_cnt_%0d", r), conflict_cnt, 32'hFFFF_FFFF);
            tick();
            data_req = 1'b0;
            tick();
        end
        settle();
        chk("sat_final", conflict_cnt, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
